ahb_lite_sram_slave: RTL and testbench
======================================

Name: ahb_lite_sram_slave

Overview:
AHB-Lite responder: a word-organised on-chip SRAM with configurable wait states and ERROR responses. It is the slave-side counterpart of the bench AHB driver. It acts as a reference target alongside the SDRAM controller on the same bus, so driver, monitor and scoreboard can be exercised against a known-good slave. Fully synthesizable.

Parameters:
MEM_DEPTH, 1024, number of 32-bit words (power of two)
BASE_ADDR, 32'h0000_0000, first byte address mapped; must be aligned to 4*MEM_DEPTH
WAIT_STATES, 0, extra data-phase cycles inserted on every OKAY transfer (0..15)

Ports:
clk  input  1  bus clock; all flops on rising edge
rst  input  1  asynchronous, active-high reset
hsel  input  1  slave select
haddr  input  32  transfer byte address
hwrite  input  1  1 = write, 0 = read
htrans  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
hsize  input  3  0 = byte, 1 = halfword, 2 = word; values above 2 are illegal
hburst  input  3  accepted, ignored (each beat handled as a single transfer)
hwdata  input  32  write data, valid in data phase
hready  input  1  bus-wide ready from the interconnect mux
hrdata  output  32  read data
hreadyout  output  1  slave ready
hresp  output  1  0 = OKAY, 1 = ERROR

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state = IDLE, hreadyout = 1, hresp = 0, hrdata = 0.
  - Latched address, write and size cleared.
  - Memory contents are NOT cleared.
- Address phase is accepted when hsel & htrans[1] & hready. On acceptance, latch haddr, hwrite and hsize. IDLE/BUSY, or hsel = 0, yields a zero-wait OKAY with no memory access.
- Transfer is classified at acceptance:
  - Error if the address is out of range (haddr - BASE_ADDR >= 4*MEM_DEPTH).
  - Error if hsize > 2.
  - Error if misaligned: halfword with haddr[0] = 1, or word with haddr[1:0] != 0.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE -> ERR1 if the accepted transfer is an error.
  - IDLE -> WAIT if WAIT_STATES > 0, else IDLE -> DATA.
  - WAIT: hreadyout = 0. A 4-bit counter loads WAIT_STATES-1 and decrements to 0, then moves to DATA.
  - DATA: hreadyout = 1, hresp = 0.
    - Read: hrdata = mem[latched word index], full word regardless of size; hrdata = 0 outside DATA reads.
    - Write: hwdata is written at the clock edge ending DATA, using byte enables from latched size and addr[1:0] (byte = 1 lane, halfword = lanes {1:0} or {3:2}, word = all).
    - A new transfer accepted in the same cycle takes the same IDLE-exit decision (pipelined back-to-back; total latency per beat = 1 + WAIT_STATES).
  - ERR1: hreadyout = 0, hresp = 1. ERR2: hreadyout = 1, hresp = 1. A transfer accepted during ERR2 is processed normally. Errored writes never modify memory.
- Read-after-write to the same word in consecutive transfers returns the new data, because the write commits before the next data phase.
- hready is low while this slave is not selected in data phase: no acceptance, state holds.
- Reset mid-transfer aborts it. A pending write is discarded and hreadyout returns to 1 immediately.

Decomposition:
- Package ahb_lite_pkg holds:
  - HTRANS, HSIZE and HRESP localparams.
  - The state enum (ahb_slv_state_t).
  - A function computing 4-bit byte enables from size and addr[1:0].
- One sub-module, ahb_sram_mem: MEM_DEPTH x 32 array with 4 byte-write enables, synchronous write and combinational read.

Test Plan:
- WAIT_STATES=0: NONSEQ word write 32'hDEADBEEF to 0x10, then read 0x10 -> hreadyout never low, read data 32'hDEADBEEF, hresp 0.
- WAIT_STATES=3: read 0x0 -> hreadyout low for exactly 3 cycles, high on the 4th data-phase cycle.
- Byte write 8'hAA to 0x21 over word 0x20 previously holding 32'h11223344 -> read 0x20 returns 32'h1122AA44.
- Word access at 0x2 and an access at BASE_ADDR + 4*MEM_DEPTH -> each gives hresp=1 for 2 cycles (hreadyout 0 then 1); memory is unchanged.
- Back-to-back SEQ burst of 4 word writes at 0x40..0x4C, followed by a 4-beat read burst -> data matches, 1 cycle per beat at WAIT_STATES=0.
- Assert rst during the WAIT state of a write to 0x80 -> hreadyout=1 and hresp=0 next cycle; a later read of 0x80 returns its old contents.

Source files
------------

// File: rtl/ahb_lite_pkg.sv
// AHB-Lite encodings, slave FSM states and byte-lane helper shared by the SRAM responder.
// Pure declarations: no latency and no flow control of its own.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } ahb_slv_state_t;

  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr;
      HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// DEPTH x 32 word store: byte-lane write commits on the clock edge, read is combinational.
// Zero read latency; always ready, no backpressure.
module ahb_sram_mem #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] idx,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM responder: 1 + WAIT_STATES cycles per OKAY beat, two-cycle ERROR response.
// Stalls the bus via hreadyout low during wait states and the first ERROR cycle.
module ahb_lite_sram_slave
  import ahb_lite_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);

  localparam int unsigned AW      = $clog2(MEM_DEPTH);
  localparam logic [32:0] SPAN    = 33'(MEM_DEPTH) << 2;
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  ahb_slv_state_t state;
  logic [31:0]    addr_q;
  logic           wr_q;
  logic [2:0]     size_q;
  logic [3:0]     wcnt;

  logic [31:0] offs;
  logic        accept;
  logic        xfer_err;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        unused_bits;

  assign offs     = haddr - BASE_ADDR;
  assign accept   = hsel & htrans[1] & hready;
  assign xfer_err = ({1'b0, offs} >= SPAN)
                  | (hsize > HSIZE_WORD)
                  | ((hsize == HSIZE_HALF) & haddr[0])
                  | ((hsize == HSIZE_WORD) & (haddr[1:0] != 2'b00));

  // IDLE, DATA and ERR2 all end with hreadyout high, so each can take the next address phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      hreadyout <= 1'b1;
      hresp     <= HRESP_OKAY;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      size_q    <= '0;
      wcnt      <= '0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (wcnt == 4'd0) begin
            state     <= ST_DATA;
            hreadyout <= 1'b1;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          hreadyout <= 1'b1;
          hresp     <= HRESP_ERROR;
        end
        default: begin
          if (accept) begin
            addr_q <= haddr;
            wr_q   <= hwrite;
            size_q <= hsize;
            if (xfer_err) begin
              state     <= ST_ERR1;
              hreadyout <= 1'b0;
              hresp     <= HRESP_ERROR;
            end else if (WAIT_STATES > 0) begin
              state     <= ST_WAIT;
              hreadyout <= 1'b0;
              hresp     <= HRESP_OKAY;
              wcnt      <= WS_LOAD;
            end else begin
              state     <= ST_DATA;
              hreadyout <= 1'b1;
              hresp     <= HRESP_OKAY;
            end
          end else begin
            state     <= ST_IDLE;
            hreadyout <= 1'b1;
            hresp     <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  // BASE_ADDR is aligned to the array span, so the low address bits index the array directly.
  assign mem_be = (state == ST_DATA && wr_q) ? byte_en(size_q, addr_q[1:0]) : 4'b0000;
  assign hrdata = (state == ST_DATA && !wr_q) ? mem_rdata : 32'h0;

  ahb_sram_mem #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .idx   (addr_q[AW+1:2]),
    .be    (mem_be),
    .wdata (hwdata),
    .rdata (mem_rdata)
  );

  assign unused_bits = ^{hburst, htrans[0], addr_q[31:AW+2]};

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: two instances (0 and 3 wait states) driven by a pipelined
// master, checked every cycle against a response-sequence model plus directed literal checks.
module tb_ahb_lite_sram_slave;
  import ahb_lite_pkg::*;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] data;
  } xfer_t;

  typedef struct packed {
    logic        rdy;
    logic        resp;
    logic        rd_fin;
    logic        wr_fin;
    logic [31:0] addr;
    logic [2:0]  size;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsel   [2];
  logic [31:0] haddr  [2];
  logic        hwrite [2];
  logic [1:0]  htrans [2];
  logic [2:0]  hsize  [2];
  logic [2:0]  hburst [2];
  logic [31:0] hwdata [2];
  logic [31:0] hrdata [2];
  logic        hreadyout [2];
  logic        hresp  [2];

  int n_chk = 0;
  int n_fail = 0;

  xfer_t       xq [$];
  exp_t        eq [2][$];
  logic [31:0] mm [2][DEPTH];
  bit          mk [2][DEPTH];
  logic [31:0] last_rd [2];
  int          lowcnt [2];
  int          respcnt [2];

  always #5 clk = ~clk;

  ahb_lite_sram_slave #(.MEM_DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst), .hsel(hsel[0]), .haddr(haddr[0]), .hwrite(hwrite[0]),
    .htrans(htrans[0]), .hsize(hsize[0]), .hburst(hburst[0]), .hwdata(hwdata[0]),
    .hready(hreadyout[0]), .hrdata(hrdata[0]), .hreadyout(hreadyout[0]), .hresp(hresp[0]));

  ahb_lite_sram_slave #(.MEM_DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3)) u3 (
    .clk(clk), .rst(rst), .hsel(hsel[1]), .haddr(haddr[1]), .hwrite(hwrite[1]),
    .htrans(htrans[1]), .hsize(hsize[1]), .hburst(hburst[1]), .hwdata(hwdata[1]),
    .hready(hreadyout[1]), .hrdata(hrdata[1]), .hreadyout(hreadyout[1]), .hresp(hresp[1]));

  function automatic int ws(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s (dut %0d) at %0t: got %h, expected %h", nm, d, $time, act, expv);
    end
  endtask

  // Model: each accepted transfer expands into the list of data-phase cycles it must produce.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      exp_t        e;
      logic        hr;
      logic [31:0] a;
      int          n;
      int          first;
      if (rst) begin
        eq[d].delete();
      end else begin
        hr = 1'b1;
        if (eq[d].size() > 0) begin
          e  = eq[d].pop_front();
          hr = e.rdy;
          if (e.wr_fin) begin
            n     = 1 << e.size;
            first = int'(e.addr[1:0]) & ~(n - 1);
            for (int b = 0; b < 4; b++)
              if (b >= first && b < first + n) mm[d][e.addr[7:2]][8*b +: 8] = hwdata[d][8*b +: 8];
            if (n == 4) mk[d][e.addr[7:2]] = 1'b1;
          end
        end
        if (hsel[d] && htrans[d][1] && hr) begin
          a = haddr[d];
          if ((a - BASE) >= 32'(4 * DEPTH) || hsize[d] > 3'd2 ||
              (a % (32'd1 << hsize[d])) != 0) begin
            eq[d].push_back('{rdy: 1'b0, resp: 1'b1, rd_fin: 1'b0, wr_fin: 1'b0, addr: a, size: hsize[d]});
            eq[d].push_back('{rdy: 1'b1, resp: 1'b1, rd_fin: 1'b0, wr_fin: 1'b0, addr: a, size: hsize[d]});
          end else begin
            for (int k = 0; k < ws(d); k++)
              eq[d].push_back('{rdy: 1'b0, resp: 1'b0, rd_fin: 1'b0, wr_fin: 1'b0, addr: a, size: hsize[d]});
            eq[d].push_back('{rdy: 1'b1, resp: 1'b0, rd_fin: !hwrite[d], wr_fin: hwrite[d],
                              addr: a, size: hsize[d]});
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      e = '{rdy: 1'b1, resp: 1'b0, rd_fin: 1'b0, wr_fin: 1'b0, addr: 32'h0, size: 3'd0};
      if (!rst && eq[d].size() > 0) e = eq[d][0];
      chk(d, "hreadyout", 32'(hreadyout[d]), 32'(e.rdy));
      chk(d, "hresp", 32'(hresp[d]), 32'(e.resp));
      if (e.rd_fin) begin
        if (mk[d][e.addr[7:2]]) chk(d, "hrdata", hrdata[d], mm[d][e.addr[7:2]]);
        last_rd[d] = hrdata[d];
      end else begin
        chk(d, "hrdata_idle", hrdata[d], 32'h0);
      end
      if (!hreadyout[d]) lowcnt[d]++;
      if (hresp[d]) respcnt[d]++;
    end
  end

  task automatic drive(input int d, input xfer_t x);
    hsel[d]   = x.sel;
    htrans[d] = x.trans;
    haddr[d]  = x.addr;
    hwrite[d] = x.wr;
    hsize[d]  = x.size;
    hburst[d] = 3'd0;
  endtask

  task automatic drive_idle(input int d);
    xfer_t x;
    x = '{sel: 1'b0, trans: HTRANS_IDLE, addr: 32'h0, wr: 1'b0, size: 3'd0, data: 32'h0};
    drive(d, x);
  endtask

  function automatic void add(input logic [1:0] tr, input logic [31:0] a, input logic wr,
                              input logic [2:0] sz, input logic [31:0] dat);
    xq.push_back('{sel: 1'b1, trans: tr, addr: a, wr: wr, size: sz, data: dat});
  endfunction

  // Pipelined master: the next address phase is presented only once the bus was ready.
  task automatic run(input int d, output int cyc);
    int i;
    int guard;
    bit r;
    cyc = 0;
    i = 0;
    guard = 0;
    @(posedge clk); #1;
    if (xq.size() > 0) drive(d, xq[0]);
    while (i < xq.size()) begin
      @(negedge clk); r = hreadyout[d];
      @(posedge clk); #1;
      cyc++;
      if (r) begin
        hwdata[d] = xq[i].data;
        i++;
        guard = 0;
        if (i < xq.size()) drive(d, xq[i]);
        else drive_idle(d);
      end else if (++guard > 50) begin
        chk(d, "run_timeout", 32'(guard), 32'd0);
        break;
      end
    end
    guard = 0;
    do begin
      @(negedge clk); r = hreadyout[d];
      @(posedge clk); #1;
      cyc++;
      guard++;
    end while (!r && guard <= 50);
    if (!r) chk(d, "final_timeout", 32'(guard), 32'd0);
    drive_idle(d);
    xq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [31:0] bd [4];
    for (int d = 0; d < 2; d++) begin
      drive_idle(d);
      hwdata[d] = 32'h0;
      lowcnt[d] = 0;
      respcnt[d] = 0;
      last_rd[d] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(0, "reset_hreadyout", 32'(hreadyout[0]), 32'd1);
    chk(0, "reset_hresp", 32'(hresp[0]), 32'd0);
    chk(1, "reset_hrdata", hrdata[1], 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < DEPTH; w++) add(HTRANS_NONSEQ, 32'(w * 4), 1'b1, HSIZE_WORD, $urandom);
      run(d, c);
    end

    // Zero wait states: write then read back.
    lowcnt[0] = 0;
    add(HTRANS_NONSEQ, 32'h10, 1'b1, HSIZE_WORD, 32'hDEADBEEF);
    add(HTRANS_NONSEQ, 32'h10, 1'b0, HSIZE_WORD, 32'h0);
    run(0, c);
    chk(0, "ws0_rd_data", last_rd[0], 32'hDEADBEEF);
    chk(0, "ws0_no_stall", 32'(lowcnt[0]), 32'd0);

    // Byte lane 1 update inside a known word.
    add(HTRANS_NONSEQ, 32'h20, 1'b1, HSIZE_WORD, 32'h11223344);
    add(HTRANS_NONSEQ, 32'h21, 1'b1, HSIZE_BYTE, 32'hFFFFAAFF);
    add(HTRANS_NONSEQ, 32'h20, 1'b0, HSIZE_WORD, 32'h0);
    run(0, c);
    chk(0, "byte_merge", last_rd[0], 32'h1122AA44);

    // Misaligned and out-of-range writes must error and leave word 0 untouched.
    add(HTRANS_NONSEQ, 32'h0, 1'b1, HSIZE_WORD, 32'hCAFE0000);
    run(0, c);
    lowcnt[0] = 0;
    respcnt[0] = 0;
    add(HTRANS_NONSEQ, 32'h2, 1'b1, HSIZE_WORD, 32'h12345678);
    add(HTRANS_NONSEQ, BASE + 32'(4 * DEPTH), 1'b1, HSIZE_WORD, 32'h87654321);
    add(HTRANS_NONSEQ, 32'h0, 1'b0, HSIZE_WORD, 32'h0);
    run(0, c);
    chk(0, "err_resp_cycles", 32'(respcnt[0]), 32'd4);
    chk(0, "err_stall_cycles", 32'(lowcnt[0]), 32'd2);
    chk(0, "err_mem_unchanged", last_rd[0], 32'hCAFE0000);

    // Four-beat write burst then read burst, one cycle per beat.
    lowcnt[0] = 0;
    for (int k = 0; k < 4; k++) begin
      bd[k] = $urandom;
      add((k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 32'(32'h40 + 4 * k), 1'b1, HSIZE_WORD, bd[k]);
    end
    for (int k = 0; k < 4; k++)
      add((k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 32'(32'h40 + 4 * k), 1'b0, HSIZE_WORD, 32'h0);
    run(0, c);
    chk(0, "burst_cycles", 32'(c), 32'd9);
    chk(0, "burst_no_stall", 32'(lowcnt[0]), 32'd0);
    chk(0, "burst_last_rd", last_rd[0], bd[3]);

    // Three wait states on a single read.
    lowcnt[1] = 0;
    add(HTRANS_NONSEQ, 32'h0, 1'b0, HSIZE_WORD, 32'h0);
    run(1, c);
    chk(1, "ws3_stall_cycles", 32'(lowcnt[1]), 32'd3);
    chk(1, "ws3_total_cycles", 32'(c), 32'd5);

    // Reset during the wait states of a write discards it.
    add(HTRANS_NONSEQ, 32'h80, 1'b1, HSIZE_WORD, 32'h0BADF00D);
    run(1, c);
    @(posedge clk); #1;
    drive(1, '{sel: 1'b1, trans: HTRANS_NONSEQ, addr: 32'h80, wr: 1'b1, size: HSIZE_WORD, data: 32'h0});
    @(posedge clk); #1;
    hwdata[1] = 32'h55555555;
    drive_idle(1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk(1, "rst_mid_hreadyout", 32'(hreadyout[1]), 32'd1);
    chk(1, "rst_mid_hresp", 32'(hresp[1]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    add(HTRANS_NONSEQ, 32'h80, 1'b0, HSIZE_WORD, 32'h0);
    run(1, c);
    chk(1, "rst_write_dropped", last_rd[1], 32'h0BADF00D);

    // Randomised traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      repeat (6) begin
        repeat (25) begin
          logic [2:0]  sz;
          logic [31:0] a;
          logic [1:0]  tr;
          int          r;
          r  = $urandom_range(0, 9);
          tr = (r == 0) ? HTRANS_IDLE : (r == 1) ? HTRANS_BUSY : (r < 6) ? HTRANS_NONSEQ : HTRANS_SEQ;
          sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
          a  = ($urandom_range(0, 14) == 0) ? 32'(4 * DEPTH) + $urandom_range(0, 1023)
                                            : 32'($urandom_range(0, 4 * DEPTH - 1));
          if (sz <= 3'd2 && $urandom_range(0, 7) != 0) a = a & ~((32'd1 << sz) - 1);
          xq.push_back('{sel: ($urandom_range(0, 7) != 0), trans: tr, addr: BASE + a,
                         wr: 1'($urandom), size: sz, data: $urandom});
        end
        run(d, c);
      end
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
